cdc_s2f_tx_sched: RTL and testbench



---
 rtl/cdc_sched_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/cdc_s2f_tx_sched.sv | 109 ++++++++++
 tb/tb_cdc_s2f_tx_sched.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cdc_sched_pkg.sv
// cdc_sched_pkg: shared types and elaboration helpers for the slow-to-fast CDC transfer scheduler.
package cdc_sched_pkg;

    typedef enum logic [1:0] {IDLE, SEND, SETTLE} state_t;

    localparam int MIN_HOLD_CYC = 1;
    localparam int MIN_GAP_CYC  = 2;

    function automatic int cnt_width(input int hold_cyc, input int gap_cyc);
        return $clog2((hold_cyc > gap_cyc ? hold_cyc : gap_cyc) + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last+1 with wrap.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_last,
    output logic [NREQ-1:0]         o_gnt,
    output logic                    o_valid
);

    localparam int LW = $clog2(NREQ);

    logic [LW-1:0] w_j;
    logic          w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_j = LW'((int'(i_last) + k) % NREQ);
            if (!w_found && i_req[w_j]) begin
                o_gnt[w_j] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/cdc_s2f_tx_sched.sv
// cdc_s2f_tx_sched: shares one slow-to-fast CDC data channel among NREQ requesters,
// holding data_en for HOLD_CYC cycles and then data stable for GAP_CYC cycles per transfer.
module cdc_s2f_tx_sched
    import cdc_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DW       = 4,
    parameter int HOLD_CYC = 1,
    parameter int GAP_CYC  = 2
) (
    input  logic               clk_a,
    input  logic               arstn,
    input  logic               cfg_enable,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    grant,
    output logic [DW-1:0]      data_in,
    output logic               data_en,
    output logic               busy
);

    localparam int CW = cnt_width(HOLD_CYC, GAP_CYC);
    localparam int LW = $clog2(NREQ);

    if (HOLD_CYC < MIN_HOLD_CYC) begin : g_bad_hold
        $error("HOLD_CYC must be at least %0d", MIN_HOLD_CYC);
    end
    if (GAP_CYC < MIN_GAP_CYC) begin : g_bad_gap
        $error("GAP_CYC must be at least %0d", MIN_GAP_CYC);
    end
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("NREQ must be in 2..8");
    end

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [LW-1:0] r_last, w_idx;
    logic [NREQ-1:0] w_gnt;
    logic          w_valid, w_start;
    logic [DW-1:0] w_word;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req   (req),
        .i_last  (r_last),
        .o_gnt   (w_gnt),
        .o_valid (w_valid)
    );

    always_comb begin
        w_idx  = '0;
        w_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_idx  = w_idx | LW'(i);
                w_word = w_word | req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_start    = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_enable && w_valid) begin
                    w_start    = 1'b1;
                    w_state_nx = SEND;
                    w_cnt_nx   = CW'(HOLD_CYC - 1);
                end
            end
            SEND: begin
                if (r_cnt == '0) begin
                    w_state_nx = SETTLE;
                    w_cnt_nx   = CW'(GAP_CYC - 1);
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            SETTLE: begin
                if (r_cnt == '0) w_state_nx = IDLE;
                else w_cnt_nx = r_cnt - CW'(1);
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // data_in is loaded only on the grant edge so the fast side never sees it move mid-transfer
    always_ff @(posedge clk_a or negedge arstn) begin
        if (!arstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= LW'(NREQ - 1);
            grant   <= '0;
            data_in <= '0;
            data_en <= 1'b0;
            busy    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_last  <= w_start ? w_idx : r_last;
            grant   <= w_start ? w_gnt : '0;
            data_in <= w_start ? w_word : data_in;
            data_en <= (w_state_nx == SEND);
            busy    <= (w_state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_cdc_s2f_tx_sched.sv
// tb_cdc_s2f_tx_sched: directed checks of grant rotation, hold/gap timing, cfg_enable gating
// and async reset for the default configuration plus a HOLD_CYC=3/GAP_CYC=4 instance.
module tb_cdc_s2f_tx_sched;

    logic        clk_a = 1'b0;
    logic        arstn = 1'b0;
    logic        cfg_enable = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] req_data = '0;
    logic [3:0]  grant;
    logic [3:0]  data_in;
    logic        data_en;
    logic        busy;

    logic [3:0]  req_b = '0;
    logic [15:0] req_data_b = '0;
    logic [3:0]  grant_b;
    logic [3:0]  data_in_b;
    logic        data_en_b;
    logic        busy_b;

    int checks = 0;
    int failures = 0;

    always #5 clk_a = ~clk_a;

    cdc_s2f_tx_sched #(.NREQ(4), .DW(4), .HOLD_CYC(1), .GAP_CYC(2)) dut (
        .clk_a      (clk_a),
        .arstn      (arstn),
        .cfg_enable (cfg_enable),
        .req        (req),
        .req_data   (req_data),
        .grant      (grant),
        .data_in    (data_in),
        .data_en    (data_en),
        .busy       (busy)
    );

    cdc_s2f_tx_sched #(.NREQ(4), .DW(4), .HOLD_CYC(3), .GAP_CYC(4)) dut_b (
        .clk_a      (clk_a),
        .arstn      (arstn),
        .cfg_enable (cfg_enable),
        .req        (req_b),
        .req_data   (req_data_b),
        .grant      (grant_b),
        .data_in    (data_in_b),
        .data_en    (data_en_b),
        .busy       (busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_a);
        #1;
    endtask

    task automatic idle_out(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_en"}, 32'(data_en), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        #1;
        idle_out("rst");
        chk("rst_data", 32'(data_in), 0);
        @(negedge clk_a);
        arstn = 1'b1;

        // single request
        req = 4'b0001;
        req_data = 16'h000A;
        tick();
        chk("t1_grant", 32'(grant), 32'b0001);
        chk("t1_en", 32'(data_en), 1);
        chk("t1_data", 32'(data_in), 32'hA);
        chk("t1_busy", 32'(busy), 1);
        req = '0;
        tick();
        chk("t1_en_low", 32'(data_en), 0);
        chk("t1_busy_s1", 32'(busy), 1);
        chk("t1_grant_low", 32'(grant), 0);
        tick();
        chk("t1_busy_s2", 32'(busy), 1);
        chk("t1_data_hold", 32'(data_in), 32'hA);
        tick();
        idle_out("t1_idle");

        // fresh reset so rotation starts at requester 0
        arstn = 1'b0;
        #1;
        arstn = 1'b1;
        req = 4'b1111;
        req_data = 16'h4321;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rot_grant", 32'(grant), 32'(1 << (k % 4)));
            chk("rot_data", 32'(data_in), 32'((k % 4) + 1));
            chk("rot_en", 32'(data_en), 1);
            if (k == 4) req = '0;
            for (int j = 0; j < 3; j++) begin
                tick();
                chk("rot_gap_grant", 32'(grant), 0);
                chk("rot_gap_en", 32'(data_en), 0);
                chk("rot_gap_data", 32'(data_in), 32'((k % 4) + 1));
                chk("rot_gap_busy", 32'(busy), 32'(j < 2));
            end
        end

        // request arriving mid-transfer waits for the next IDLE cycle
        req = 4'b0001;
        tick();
        chk("late_g0", 32'(grant), 32'b0001);
        req = 4'b0100;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("late_wait", 32'(grant), 0);
        end
        tick();
        chk("late_g2", 32'(grant), 32'b0100);
        chk("late_data", 32'(data_in), 32'h3);
        req = '0;
        for (int j = 0; j < 3; j++) tick();
        idle_out("late_idle");

        // cfg_enable dropped mid-SEND
        req = 4'b1111;
        tick();
        chk("cfg_g3", 32'(grant), 32'b1000);
        chk("cfg_data", 32'(data_in), 32'h4);
        cfg_enable = 1'b0;
        tick();
        chk("cfg_settle_busy", 32'(busy), 1);
        tick();
        chk("cfg_settle_busy2", 32'(busy), 1);
        for (int j = 0; j < 6; j++) begin
            tick();
            idle_out("cfg_off");
        end
        cfg_enable = 1'b1;
        tick();
        chk("cfg_resume", 32'(grant), 32'b0001);
        chk("cfg_resume_data", 32'(data_in), 32'h1);
        req = '0;
        for (int j = 0; j < 3; j++) tick();

        // async reset mid-SEND
        req = 4'b1111;
        tick();
        chk("ar_pre", 32'(grant), 32'b0010);
        #2;
        arstn = 1'b0;
        #1;
        idle_out("ar_async");
        chk("ar_data", 32'(data_in), 0);
        #1;
        arstn = 1'b1;
        tick();
        chk("ar_first", 32'(grant), 32'b0001);
        req = '0;

        // HOLD_CYC=3, GAP_CYC=4 instance: period 8, enable high 3 cycles
        req_b = 4'b0001;
        req_data_b = 16'h0005;
        for (int n = 1; n <= 12; n++) begin
            tick();
            chk("p_en", 32'(data_en_b), 32'((n >= 1 && n <= 3) || (n >= 9 && n <= 11)));
            chk("p_grant", 32'(grant_b), (n == 1 || n == 9) ? 32'b0001 : 32'b0);
            chk("p_busy", 32'(busy_b), 32'(n != 8));
            chk("p_data", 32'(data_in_b), 32'h5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
